// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter for a shared HD44780 8-bit write bus. It captures one byte per grant,
// drives the setup/enable/hold strobe, then keeps the bus busy for the LCD execution time.
module lcd_bus_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int SETUP_CYCLES = 2,
  parameter int EN_CYCLES    = 25,
  parameter int HOLD_CYCLES  = 2,
  parameter int CMD_WAIT     = 2000,
  parameter int CLR_WAIT     = 80000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   lock,
  input  logic [NUM_REQ-1:0]   req_rs,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 rs,
  output logic                 rw,
  output logic                 enable,
  output logic [7:0]           data
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAX_A   = (SETUP_CYCLES > EN_CYCLES) ? SETUP_CYCLES : EN_CYCLES;
  localparam int MAX_B   = (HOLD_CYCLES > CMD_WAIT) ? HOLD_CYCLES : CMD_WAIT;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_MAX = (MAX_C > CLR_WAIT) ? MAX_C : CLR_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   EN_LD    = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0]   HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CMD_LD   = CNT_W'(CMD_WAIT - 1);
  localparam logic [CNT_W-1:0]   CLR_LD   = CNT_W'(CLR_WAIT - 1);
  localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [IDX_W-1:0]   PTR_RST  = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [NUM_REQ-1:0] NONE     = {NUM_REQ{1'b0}};

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_t;

  // Clear display (01) and return home (02/03) need the long execution time.
  function automatic logic is_long_cmd(input logic rs_v, input logic [7:0] d);
    return (rs_v == 1'b0) && ((d == 8'h01) || (d == 8'h02) || (d == 8'h03));
  endfunction

  state_t               state_r, state_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [IDX_W-1:0]     ptr_r, ptr_s;
  logic [NUM_REQ-1:0]   grant_r, grant_s, ack_r, ack_s;
  logic                 busy_r, busy_s, rs_r, rs_s, enable_r;
  logic [7:0]           data_r, data_s;
  logic                 owner_lock_s, rr_vld_s, win_vld_s;
  logic [IDX_W-1:0]     rr_idx_s, win_idx_s;
  int                   cand_s;

  // Winner selection: a locked owner keeps the bus, otherwise round-robin after ptr_r.
  always_comb begin
    owner_lock_s = (grant_r != NONE) && lock[ptr_r];
    rr_vld_s     = 1'b0;
    rr_idx_s     = ptr_r;
    cand_s       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = (int'(ptr_r) + k) % NUM_REQ;
      if (!rr_vld_s && req[cand_s]) begin
        rr_vld_s = 1'b1;
        rr_idx_s = IDX_W'(cand_s);
      end else begin
        rr_vld_s = rr_vld_s;
      end
    end
    if (owner_lock_s) begin
      win_vld_s = req[ptr_r];
      win_idx_s = ptr_r;
    end else begin
      win_vld_s = rr_vld_s;
      win_idx_s = rr_idx_s;
    end
  end

  // Next-state, shared counter reload and next values of the registered outputs.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    ptr_s   = ptr_r;
    grant_s = grant_r;
    ack_s   = NONE;
    busy_s  = busy_r;
    rs_s    = rs_r;
    data_s  = data_r;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        if (!owner_lock_s) begin
          grant_s = NONE;
        end else begin
          grant_s = grant_r;
        end
        if (win_vld_s) begin
          state_s = SETUP;
          cnt_s   = SETUP_LD;
          ptr_s   = win_idx_s;
          grant_s = ONE_HOT0 << win_idx_s;
          ack_s   = ONE_HOT0 << win_idx_s;
          busy_s  = 1'b1;
          rs_s    = req_rs[win_idx_s];
          data_s  = req_data[{win_idx_s, 3'b000} +: 8];
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = PULSE;
          cnt_s   = EN_LD;
        end else begin
          cnt_s = cnt_r - 1'b1;
        end
      end
      PULSE: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = HOLD;
          cnt_s   = HOLD_LD;
        end else begin
          cnt_s = cnt_r - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = WAIT;
          cnt_s   = is_long_cmd(rs_r, data_r) ? CLR_LD : CMD_LD;
        end else begin
          cnt_s = cnt_r - 1'b1;
        end
      end
      WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = IDLE;
          busy_s  = 1'b0;
          grant_s = lock[ptr_r] ? grant_r : NONE;
        end else begin
          cnt_s = cnt_r - 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
        grant_s = NONE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; enable follows PULSE one cycle later so rs/data lead it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= CNT_ZERO;
      ptr_r    <= PTR_RST;
      grant_r  <= NONE;
      ack_r    <= NONE;
      busy_r   <= 1'b0;
      rs_r     <= 1'b0;
      data_r   <= 8'h00;
      enable_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      ptr_r    <= ptr_s;
      grant_r  <= grant_s;
      ack_r    <= ack_s;
      busy_r   <= busy_s;
      rs_r     <= rs_s;
      data_r   <= data_s;
      enable_r <= (state_r == PULSE);
    end
  end

  assign ack    = ack_r;
  assign grant  = grant_r;
  assign busy   = busy_r;
  assign rs     = rs_r;
  assign rw     = 1'b0;
  assign enable = enable_r;
  assign data   = data_r;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter: a vector table of single-word transfers plus
// hand-written sequences for round-robin rotation, locked bursts and reset mid-strobe.
module tb_lcd_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = 3'b000, lock = 3'b000, req_rs = 3'b000;
  logic [23:0] req_data = 24'h0;
  logic [2:0]  ack, grant;
  logic        busy, rs, rw, enable;
  logic [7:0]  data;

  int n_cmp = 0;
  int n_fail = 0;

  lcd_bus_arbiter #(
    .NUM_REQ(3), .SETUP_CYCLES(1), .EN_CYCLES(2), .HOLD_CYCLES(1),
    .CMD_WAIT(4), .CLR_WAIT(10)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .req_rs(req_rs),
    .req_data(req_data), .ack(ack), .grant(grant), .busy(busy), .rs(rs),
    .rw(rw), .enable(enable), .data(data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] req;
    logic [2:0] rs;
    logic [7:0] d0;
    logic [2:0] e_grant;
    logic       e_rs;
    logic [7:0] e_data;
    int         e_lat;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = 3'b000;
    lock = 3'b000;
    step();
    step();
    reset = 1'b0;
  endtask

  // One full transfer: inputs applied in an IDLE cycle (cycle 0), then followed to the next IDLE.
  task automatic xfer(input string nm, input logic [2:0] t_req, input logic [2:0] t_lock,
                      input logic [2:0] t_rs, input logic [7:0] d0, input logic [7:0] d1,
                      input logic [2:0] a_req, input logic [2:0] a_lock,
                      input logic [2:0] e_grant, input logic e_rs, input logic [7:0] e_data,
                      input int e_lat);
    int cyc, en_first, en_cnt, extra_ack;
    logic stable;
    logic [2:0] e_idle_grant;
    req = t_req;
    lock = t_lock;
    req_rs = t_rs;
    req_data = {8'hC2, d1, d0};
    step();
    chk({nm, "_ack"}, 32'(ack), 32'(e_grant));
    chk({nm, "_grant"}, 32'(grant), 32'(e_grant));
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    chk({nm, "_rs"}, 32'(rs), 32'(e_rs));
    chk({nm, "_data"}, 32'(data), 32'(e_data));
    req = a_req;
    lock = a_lock;
    cyc = 1;
    en_first = 0;
    en_cnt = 0;
    extra_ack = 0;
    stable = 1'b1;
    while (cyc < 200) begin
      step();
      cyc++;
      if (enable) begin
        if (en_cnt == 0) en_first = cyc;
        en_cnt++;
      end
      if (ack != 3'b000) extra_ack++;
      if (rs !== e_rs || data !== e_data || rw !== 1'b0) stable = 1'b0;
      if (!busy) break;
    end
    e_idle_grant = ((a_lock & e_grant) != 3'b000) ? e_grant : 3'b000;
    chk({nm, "_latency"}, 32'(cyc), 32'(e_lat));
    chk({nm, "_en_first"}, 32'(en_first), 32'd3);
    chk({nm, "_en_len"}, 32'(en_cnt), 32'd2);
    chk({nm, "_single_ack"}, 32'(extra_ack), 32'd0);
    chk({nm, "_bus_stable"}, 32'(stable), 32'd1);
    chk({nm, "_idle_grant"}, 32'(grant), 32'(e_idle_grant));
  endtask

  initial begin
    vecs[0]  = '{3'b001, 3'b000, 8'h38, 3'b001, 1'b0, 8'h38, 9};
    vecs[1]  = '{3'b001, 3'b000, 8'h01, 3'b001, 1'b0, 8'h01, 15};
    vecs[2]  = '{3'b001, 3'b001, 8'h01, 3'b001, 1'b1, 8'h01, 9};
    vecs[3]  = '{3'b001, 3'b000, 8'h02, 3'b001, 1'b0, 8'h02, 15};
    vecs[4]  = '{3'b001, 3'b000, 8'h03, 3'b001, 1'b0, 8'h03, 15};
    vecs[5]  = '{3'b001, 3'b000, 8'h04, 3'b001, 1'b0, 8'h04, 9};
    vecs[6]  = '{3'b001, 3'b000, 8'h00, 3'b001, 1'b0, 8'h00, 9};
    vecs[7]  = '{3'b011, 3'b010, 8'h55, 3'b010, 1'b1, 8'hB1, 9};
    vecs[8]  = '{3'b101, 3'b100, 8'h55, 3'b100, 1'b1, 8'hC2, 9};
    vecs[9]  = '{3'b101, 3'b000, 8'h01, 3'b001, 1'b0, 8'h01, 15};
    vecs[10] = '{3'b110, 3'b000, 8'h55, 3'b010, 1'b0, 8'hB1, 9};

    do_reset();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rs", 32'(rs), 32'd0);
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_rw", 32'(rw), 32'd0);

    // Single-word transfers; round-robin pointer carries over from vector to vector.
    for (int i = 0; i < 11; i++) begin
      xfer($sformatf("v%0d", i), vecs[i].req, 3'b000, vecs[i].rs, vecs[i].d0, 8'hB1,
           3'b000, 3'b000, vecs[i].e_grant, vecs[i].e_rs, vecs[i].e_data, vecs[i].e_lat);
    end

    // All three requesting continuously without lock: strict rotation.
    do_reset();
    xfer("rr0", 3'b111, 3'b000, 3'b000, 8'h38, 8'hB1, 3'b111, 3'b000, 3'b001, 1'b0, 8'h38, 9);
    xfer("rr1", 3'b111, 3'b000, 3'b000, 8'h38, 8'hB1, 3'b111, 3'b000, 3'b010, 1'b0, 8'hB1, 9);
    xfer("rr2", 3'b111, 3'b000, 3'b000, 8'h38, 8'hB1, 3'b111, 3'b000, 3'b100, 1'b0, 8'hC2, 9);
    xfer("rr3", 3'b111, 3'b000, 3'b000, 8'h38, 8'hB1, 3'b000, 3'b000, 3'b001, 1'b0, 8'h38, 9);

    // Locked burst from requester 1 while requester 0 waits.
    do_reset();
    xfer("burst0", 3'b010, 3'b010, 3'b010, 8'h20, 8'h40, 3'b011, 3'b010, 3'b010, 1'b1, 8'h40, 9);
    xfer("burst1", 3'b011, 3'b010, 3'b010, 8'h20, 8'h41, 3'b011, 3'b010, 3'b010, 1'b1, 8'h41, 9);
    xfer("burst2", 3'b011, 3'b010, 3'b010, 8'h20, 8'h42, 3'b011, 3'b010, 3'b010, 1'b1, 8'h42, 9);
    xfer("burst3", 3'b011, 3'b010, 3'b010, 8'h20, 8'h43, 3'b001, 3'b010, 3'b010, 1'b1, 8'h43, 9);
    // Owner still locked but idle: requester 0 stays blocked.
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("blocked%0d_ack", i), 32'(ack), 32'd0);
      chk($sformatf("blocked%0d_grant", i), 32'(grant), 32'b010);
      chk($sformatf("blocked%0d_busy", i), 32'(busy), 32'd0);
    end
    xfer("unlock", 3'b001, 3'b000, 3'b000, 8'h20, 8'h43, 3'b000, 3'b000, 3'b001, 1'b0, 8'h20, 9);

    // Reset while enable is high.
    req = 3'b001;
    req_rs = 3'b000;
    req_data = {8'hC2, 8'hB1, 8'h38};
    step();
    req = 3'b000;
    step();
    step();
    chk("abort_pre_enable", 32'(enable), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_enable", 32'(enable), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_grant", 32'(grant), 32'd0);
    chk("abort_data", 32'(data), 32'd0);
    chk("abort_ack", 32'(ack), 32'd0);
    xfer("post_rst", 3'b110, 3'b000, 3'b000, 8'h38, 8'hB1, 3'b000, 3'b000, 3'b010, 1'b0, 8'hB1, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
